memory_arbiter: RTL and testbench

//  Shares the single RAM port between instruction fetch and data (lw/sw) access.

---
 rtl/memory_arbiter_if.sv | 30 +++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Datapath- and RAM-facing signal bundle for the memory arbiter.
// The arbiter takes the slave view; the datapath/RAM side takes the master view.
interface memory_arbiter_if;
    logic        iren;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramren;
    logic        ramwen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access: one registered
// grant at a time, held until ACCESS, with anti-starvation for fetch and a timeout.
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    memory_arbiter_if.slave     bus_io,
    output logic                err_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;

    logic        d_req;
    logic        ram_access;
    logic        ram_error;
    logic        grant_req;
    logic        i_done;
    logic        d_done;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;

    assign d_req      = bus_io.dren | bus_io.dwen;
    assign ram_access = (bus_io.ramstate == RS_ACCESS);
    assign ram_error  = (bus_io.ramstate == RS_ERROR);
    assign grant_req  = ((state_q == IGNT) & bus_io.iren) | ((state_q == DGNT) & d_req);
    assign i_done     = (state_q == IGNT) & bus_io.iren & ram_access;
    assign d_done     = (state_q == DGNT) & d_req & ram_access;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!bus_io.iren) begin
                    starve_d = '0;
                end
                if (bus_io.iren && (starve_q == SW'(STARVE_MAX))) begin
                    state_d = IGNT;
                end else if (d_req) begin
                    state_d = DGNT;
                end else if (bus_io.iren) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                ram_ren  = bus_io.iren;
                ram_addr = bus_io.iaddr;
            end
            DGNT: begin
                ram_addr  = bus_io.daddr;
                ram_store = bus_io.dstore;
                // A simultaneous read and write request is served as the write.
                ram_wen   = bus_io.dwen;
                ram_ren   = bus_io.dren & ~bus_io.dwen;
            end
            default: state_d = IDLE;
        endcase

        // Common grant handling: abort, completion, RAM error, timeout.
        if (state_q == IGNT || state_q == DGNT) begin
            if (!grant_req) begin
                state_d = IDLE;
            end else if (ram_access) begin
                state_d = IDLE;
            end else if (ram_error) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (i_done) begin
            starve_d = '0;
        end else if (d_done && bus_io.iren && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign bus_io.ramren   = ram_ren;
    assign bus_io.ramwen   = ram_wen;
    assign bus_io.ramaddr  = ram_addr;
    assign bus_io.ramstore = ram_store;

    assign bus_io.iwait = bus_io.iren & ~((state_q == IGNT) & ram_access);
    assign bus_io.dwait = d_req & ~((state_q == DGNT) & ram_access);
    assign bus_io.iload = i_done ? bus_io.ramload : 32'h0;
    assign bus_io.dload = d_done ? bus_io.ramload : 32'h0;

    assign err_o = err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: cycle checks per scenario plus an
// in-order completion scoreboard fed by the stimulus tasks.
module tb_memory_arbiter;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst;
    logic err;

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus.slave),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mode     = 0;   // 0: ACCESS 2 cycles after strobe, 1: stuck BUSY, 2: ERROR
    int   lat_cnt  = 0;
    int   d_done_cnt = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2108000A : ((a ^ 32'h5A5A0000) + 32'h11);
    endfunction

    // RAM model
    always_comb begin
        bus.ramstate = RS_FREE;
        bus.ramload  = 32'h0;
        if (bus.ramren || bus.ramwen) begin
            case (mode)
                0:       bus.ramstate = (lat_cnt >= 2) ? RS_ACCESS : RS_BUSY;
                1:       bus.ramstate = RS_BUSY;
                default: bus.ramstate = RS_ERROR;
            endcase
        end
        if (bus.ramstate == RS_ACCESS && bus.ramren) bus.ramload = word_at(bus.ramaddr);
    end

    always @(posedge clk) begin
        if ((bus.ramren || bus.ramwen) && bus.ramstate != RS_ACCESS) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end

    // Completion monitor / scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.iren && !bus.iwait) begin
                n_checks++;
                $display("txn fetch addr=%h iload=%h", bus.ramaddr, bus.iload);
                if (sb_q.size() == 0) $display("FAIL sb_fetch: unexpected completion iload=%h, none required", bus.iload);
                else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_d !== 1'b0 || bus.iload !== mon_e.data)
                        $display("FAIL sb_fetch: got kind=fetch iload=%h, required kind=%s data=%h", bus.iload, mon_e.is_d ? "data" : "fetch", mon_e.data);
                    else n_pass++;
                end
            end
            if ((bus.dren || bus.dwen) && !bus.dwait) begin
                n_checks++;
                $display("txn data addr=%h wr=%0d dload=%h", bus.ramaddr, bus.dwen, bus.dload);
                if (sb_q.size() == 0) $display("FAIL sb_data: unexpected completion dload=%h, none required", bus.dload);
                else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_d !== 1'b1 || (mon_e.chk && bus.dload !== mon_e.data))
                        $display("FAIL sb_data: got kind=data dload=%h, required kind=%s data=%h", bus.dload, mon_e.is_d ? "data" : "fetch", mon_e.data);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iren = 1'b1; bus.iaddr = '0; bus.dren = 1'b0; bus.dwen = 1'b1;
        bus.daddr = '0; bus.dstore = '0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if ({bus.ramren, bus.ramwen, bus.iwait, bus.dwait, err} !== 5'b00110) $display("FAIL rst_outs: got %b want 00110", {bus.ramren, bus.ramwen, bus.iwait, bus.dwait, err}); else n_pass++;
        @(negedge clk);
        bus.iren = 1'b0; bus.dwen = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.ramren, bus.ramwen, bus.iwait, bus.dwait, err} !== 5'b0) $display("FAIL idle_flags: got %b want 00000", {bus.ramren, bus.ramwen, bus.iwait, bus.dwait, err}); else n_pass++;
        n_checks++; if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'h0) $display("FAIL idle_buses: got %h want 0", {bus.ramaddr, bus.ramstore, bus.iload, bus.dload}); else n_pass++;
    endtask

    task automatic test_fetch();
        tick();
        bus.iaddr = 32'h40; bus.iren = 1'b1;
        sb_q.push_back('{is_d: 1'b0, chk: 1'b1, data: 32'h2108000A});
        @(negedge clk);
        n_checks++; if ({bus.ramren, bus.iwait} !== 2'b01 || bus.iload !== 32'h0) $display("FAIL fetch_c0: got ren/iwait=%b iload=%h want 01/0", {bus.ramren, bus.iwait}, bus.iload); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.ramren, bus.iwait} !== 2'b11 || bus.ramaddr !== 32'h40) $display("FAIL fetch_c1: got ren/iwait=%b addr=%h want 11/40", {bus.ramren, bus.iwait}, bus.ramaddr); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.iwait !== 1'b1) $display("FAIL fetch_c2: got iwait=%b want 1", bus.iwait); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'h2108000A) $display("FAIL fetch_c3: got iwait=%b iload=%h want 0/2108000a", bus.iwait, bus.iload); else n_pass++;
        tick();
        bus.iren = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.ramren !== 1'b0 || bus.iload !== 32'h0) $display("FAIL fetch_after: got ren=%b iload=%h want 0/0", bus.ramren, bus.iload); else n_pass++;
    endtask

    task automatic test_contention();
        tick();
        bus.iren = 1'b1; bus.iaddr = 32'h44; bus.dren = 1'b1; bus.daddr = 32'h100;
        sb_q.push_back('{is_d: 1'b1, chk: 1'b1, data: word_at(32'h100)});
        sb_q.push_back('{is_d: 1'b0, chk: 1'b1, data: word_at(32'h44)});
        @(negedge clk);
        n_checks++; if ({bus.ramren, bus.iwait, bus.dwait} !== 3'b011) $display("FAIL cont_c0: got %b want 011", {bus.ramren, bus.iwait, bus.dwait}); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.ramren !== 1'b1 || bus.ramaddr !== 32'h100 || bus.iwait !== 1'b1) $display("FAIL cont_dgnt: got ren=%b addr=%h iwait=%b want 1/100/1", bus.ramren, bus.ramaddr, bus.iwait); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus.dwait, bus.iwait} !== 2'b01) $display("FAIL cont_dacc: got dwait/iwait=%b want 01", {bus.dwait, bus.iwait}); else n_pass++;
        tick();
        bus.dren = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.ramren, bus.iwait} !== 2'b01) $display("FAIL cont_idle: got ren/iwait=%b want 01", {bus.ramren, bus.iwait}); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.ramren !== 1'b1 || bus.ramaddr !== 32'h44 || bus.iwait !== 1'b1) $display("FAIL cont_ignt: got ren=%b addr=%h iwait=%b want 1/44/1", bus.ramren, bus.ramaddr, bus.iwait); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.iwait !== 1'b0) $display("FAIL cont_iacc: got iwait=%b want 0", bus.iwait); else n_pass++;
        tick();
        bus.iren = 1'b0;
    endtask

    task automatic test_write_over_read();
        tick();
        bus.dren = 1'b1; bus.dwen = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        sb_q.push_back('{is_d: 1'b1, chk: 1'b0, data: 32'h0});
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus.ramwen, bus.ramren} !== 2'b10 || bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h200) $display("FAIL wr_strobe: got wen/ren=%b store=%h addr=%h want 10/deadbeef/200", {bus.ramwen, bus.ramren}, bus.ramstore, bus.ramaddr); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.dwait !== 1'b1) $display("FAIL wr_wait: got dwait=%b want 1", bus.dwait); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.dwait !== 1'b0) $display("FAIL wr_done: got dwait=%b want 0", bus.dwait); else n_pass++;
        tick();
        bus.dren = 1'b0; bus.dwen = 1'b0; bus.dstore = 32'h0;
    endtask

    task automatic test_starvation();
        d_done_cnt = 0;
        tick();
        bus.iren = 1'b1; bus.iaddr = 32'h48; bus.dren = 1'b1; bus.daddr = 32'h300;
        for (int k = 0; k < 4; k++) sb_q.push_back('{is_d: 1'b1, chk: 1'b1, data: word_at(32'h300 + 32'(4 * k))});
        sb_q.push_back('{is_d: 1'b0, chk: 1'b1, data: word_at(32'h48)});
        sb_q.push_back('{is_d: 1'b1, chk: 1'b1, data: word_at(32'h310)});
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    bit ok;
                    ok = 1'b0;
                    bus.daddr = 32'h300 + 32'(4 * k);
                    bus.dren = 1'b1;
                    for (int c = 0; c < BOUND; c++) begin
                        @(negedge clk);
                        if (!bus.dwait) begin ok = 1'b1; break; end
                    end
                    if (!ok) begin n_checks++; $display("FAIL starve_data_tmo: request %0d not served, required completion", k); end
                    d_done_cnt++;
                    tick();
                end
                bus.dren = 1'b0;
            end
            begin
                bit ok;
                ok = 1'b0;
                for (int c = 0; c < BOUND; c++) begin
                    @(negedge clk);
                    if (bus.iren && !bus.iwait) begin ok = 1'b1; break; end
                end
                n_checks++;
                if (!ok) $display("FAIL starve_fetch_tmo: fetch not served, required completion");
                else if (d_done_cnt !== 4) $display("FAIL starve_order: got %0d data grants before fetch, want 4", d_done_cnt);
                else n_pass++;
                tick();
                bus.iren = 1'b0;
            end
        join
    endtask

    task automatic test_faults();
        int  g;
        bit  ok;
        mode = 1;
        tick();
        bus.iren = 1'b1; bus.iaddr = 32'h50;
        sb_q.push_back('{is_d: 1'b0, chk: 1'b1, data: word_at(32'h50)});
        g = 0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.ramren) g++;
            if (err) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || g != 255) $display("FAIL tmo_cycles: got err=%b after %0d granted cycles, want err=1 after 255", err, g); else n_pass++;
        n_checks++; if ({bus.ramren, bus.iwait} !== 2'b01) $display("FAIL tmo_idle: got ren/iwait=%b want 01", {bus.ramren, bus.iwait}); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.ramren !== 1'b1 || bus.iwait !== 1'b1) $display("FAIL tmo_rearb: got ren=%b iwait=%b want 1/1", bus.ramren, bus.iwait); else n_pass++;
        mode = 2;
        @(negedge clk);
        n_checks++; if ({err, bus.ramren, bus.iwait} !== 3'b101) $display("FAIL ramerr: got err/ren/iwait=%b want 101", {err, bus.ramren, bus.iwait}); else n_pass++;
        mode = 0;
        ok = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (!bus.iwait) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || err !== 1'b1) $display("FAIL err_sticky: got served=%b err=%b want 1/1", ok, err); else n_pass++;
        tick();
        bus.iren = 1'b0;
        // Reset in the middle of a stuck grant
        mode = 1;
        tick();
        bus.iren = 1'b1; bus.iaddr = 32'h54;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.ramren !== 1'b1) $display("FAIL midrst_pre: got ren=%b want 1", bus.ramren); else n_pass++;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({err, bus.ramren, bus.iwait} !== 3'b001) $display("FAIL midrst: got err/ren/iwait=%b want 001", {err, bus.ramren, bus.iwait}); else n_pass++;
        bus.iren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        repeat (2) @(negedge clk);
        n_checks++; if ({err, bus.ramren} !== 2'b00) $display("FAIL midrst_after: got err/ren=%b want 00", {err, bus.ramren}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_write_over_read();
        test_starvation();
        test_faults();
        n_checks++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending completions, want 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
